seq_mult_collector: RTL and testbench

Receive-side companion of `seq_mult`. It accepts the multiplier's serial product stream, a P-bit chunk per `newOut` strobe, least-significant chunk first. It reassembles the chunks into a right-aligned, sign-extended 2W-bit product and presents the result on a valid/ready output port. Its `chunk_ready` output drives `seq_mult.ready_out`, so the multiplier pauses instead of losing chunks when the output side back-pressures.

---
 rtl/seq_mult_pkg.sv | 21 ++
 rtl/seq_mult_collector_if.sv | 25 ++
 rtl/seq_mult_collector.sv | 108 ++++++++++
 tb/tb_seq_mult_collector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for seq_mult and its receive-side collector:
// operand-width clamp, chunk-count helper and the collector FSM states.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } coll_state_e;

  // A zero or oversized bitSize means "use the full operand width".
  function automatic int unsigned eff_bits(input logic [3:0] bit_size, input int unsigned w);
    if (bit_size == 4'd0 || 32'(bit_size) > w) return w;
    return 32'(bit_size);
  endfunction

  function automatic int unsigned n_chunks(input int unsigned bs, input int unsigned p);
    return (2 * bs + p - 1) / p;
  endfunction

endpackage

// File: rtl/seq_mult_collector_if.sv
// Chunk-in / product-out signal bundle between seq_mult, the collector and
// the downstream consumer.
interface seq_mult_collector_if #(
  parameter int P = 2,
  parameter int W = 8
);
  logic [P-1:0]   p;
  logic           newOut;
  logic [3:0]     bitSize;
  logic           chunk_ready;
  logic [2*W-1:0] product;
  logic           valid_out;
  logic           ready_out;
  logic           overrun;

  modport master (
    output p, newOut, bitSize, ready_out,
    input  chunk_ready, product, valid_out, overrun
  );

  modport slave (
    input  p, newOut, bitSize, ready_out,
    output chunk_ready, product, valid_out, overrun
  );
endinterface

// File: rtl/seq_mult_collector.sv
// Reassembles the LSB-first serial product stream of seq_mult into a
// sign-extended 2W-bit result behind a valid/ready output register.
module seq_mult_collector
  import seq_mult_pkg::*;
#(
  parameter int P = 2,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_mult_collector_if.slave bus
);

  localparam int PW    = 2 * W;
  localparam int NMAX  = PW / P;
  localparam int CNT_W = $clog2(NMAX + 1);
  localparam int BS_W  = $clog2(W + 1);

  coll_state_e            state, state_nx;
  logic [PW-1:0]          sr;
  logic [CNT_W-1:0]       cnt, n_q, n_in;
  logic [BS_W-1:0]        bs_q, bs_in;
  logic                   acc, xfer, chunk_ready;
  logic signed [PW-1:0]   assembled, product_q;
  logic                   valid_q, overrun_q;

  // Chunks enter at the top, so after N of them the first chunk sits at
  // bit PW-N*P; shift down, then drop everything above bit 2*bs-1 and
  // replicate that bit upwards.
  function automatic logic signed [PW-1:0] align_sext(
    input logic [PW-1:0]    s,
    input logic [CNT_W-1:0] n,
    input logic [BS_W-1:0]  bs
  );
    logic [PW-1:0] r;
    int            sh;
    r  = s >> (PW - int'(n) * P);
    sh = PW - 2 * int'(bs);
    return $signed(r << sh) >>> sh;
  endfunction

  assign bs_in       = BS_W'(eff_bits(bus.bitSize, W));
  assign n_in        = CNT_W'(n_chunks(eff_bits(bus.bitSize, W), P));
  assign chunk_ready = (state != FULL);
  assign acc         = bus.newOut & chunk_ready;
  assign assembled   = align_sext(sr, n_q, bs_q);

  always_comb begin
    state_nx = state;
    xfer     = 1'b0;
    unique case (state)
      IDLE:    if (acc) state_nx = (n_in == CNT_W'(1)) ? FULL : COLLECT;
      COLLECT: if (acc && (cnt + 1'b1) == n_q) state_nx = FULL;
      FULL: begin
        xfer = !valid_q || bus.ready_out;
        if (xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Collection stage: FSM, width/count latch and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      n_q   <= '0;
      bs_q  <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        if (state == IDLE) begin
          sr   <= {bus.p, {(PW-P){1'b0}}};
          cnt  <= CNT_W'(1);
          n_q  <= n_in;
          bs_q <= bs_in;
        end else begin
          sr  <= {bus.p, sr[PW-1:P]};
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Output stage: result register with valid/ready, sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (xfer) begin
        product_q <= assembled;
        valid_q   <= 1'b1;
      end else if (valid_q && bus.ready_out) begin
        valid_q <= 1'b0;
      end
      if (bus.newOut && !chunk_ready) overrun_q <= 1'b1;
    end
  end

  assign bus.chunk_ready = chunk_ready;
  assign bus.product     = product_q;
  assign bus.valid_out   = valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_seq_mult_collector.sv
// Bench for seq_mult_collector: directed vectors, backpressure, async reset
// and randomized signed products checked against plain integer arithmetic.
module tb_seq_mult_collector;

  localparam int P  = 2;
  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult_collector_if #(.P(P), .W(W)) bus ();

  seq_mult_collector #(.P(P), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q[$];
  bit   rnd_rdy   = 1'b0;
  logic rdy_force = 1'b1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ready_out changes shortly after each rising edge
  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.ready_out = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Output monitor: in-order scoreboard plus hold-stability
  logic [PW-1:0] held;
  bit holding = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && bus.valid_out)
        chk_eq("hold_stable", 32'(bus.product), 32'(held));
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) chk_eq("spurious_out", 32'(exp_q.size()), 32'd1);
        else chk_eq("product", 32'(bus.product), 32'(exp_q.pop_front()));
      end
      holding = bus.valid_out && !bus.ready_out;
      held    = bus.product;
    end
  end

  task automatic send_chunk(input logic [P-1:0] c);
    int t = 0;
    @(negedge clk);
    while (!bus.chunk_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.chunk_ready) begin
      chk_eq("chunk_wait", 32'(bus.chunk_ready), 32'd1);
      return;
    end
    bus.p      = c;
    bus.newOut = 1'b1;
    @(posedge clk);
    #1 bus.newOut = 1'b0;
  endtask

  function automatic int eff_w(input int raw);
    return (raw == 0 || raw > W) ? W : raw;
  endfunction

  // Streams the low 2*bs bits of value LSB-first and queues the expectation.
  task automatic send_value(input int bsz, input logic [PW-1:0] value,
                            input logic [PW-1:0] expv, input bit mid_change,
                            input bit gaps);
    int bse = eff_w(bsz);
    int n   = (2 * bse + P - 1) / P;
    logic [PW-1:0] v = value;
    exp_q.push_back(expv);
    bus.bitSize = 4'(bsz);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_chunk(v[P-1:0]);
      v = v >> P;
      if (mid_change && i == 0) bus.bitSize = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int bs_raw, bse, a, b, prod;
    bus.p = '0;
    bus.newOut = 1'b0;
    bus.bitSize = 4'd4;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_valid", 32'(bus.valid_out), 32'd0);
    chk_eq("rst_product", 32'(bus.product), 32'd0);
    chk_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    chk_eq("rst_chunk_ready", 32'(bus.chunk_ready), 32'd1);
    rst_n = 1'b1;

    // -3 x -3, with latency check
    send_value(4, 16'h0009, 16'h0009, 1'b0, 1'b0);
    @(negedge clk);
    chk_eq("lat_full_ready", 32'(bus.chunk_ready), 32'd0);
    chk_eq("lat_pre_valid", 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    chk_eq("lat_valid", 32'(bus.valid_out), 32'd1);
    chk_eq("lat_product", 32'(bus.product), 32'h0009);

    send_value(4, 16'h00F1, 16'hFFF1, 1'b0, 1'b0);
    send_value(8, 16'hB6A4, 16'hB6A4, 1'b0, 1'b0);
    send_value(0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    send_value(12, 16'h8001, 16'h8001, 1'b0, 1'b0);
    send_value(1, 16'h0002, 16'hFFFE, 1'b0, 1'b0);
    send_value(4, 16'h00F1, 16'hFFF1, 1'b1, 1'b1);
    wait_drain();

    // Output backpressure: one product parked, the next stalls in FULL
    rdy_force = 1'b0;
    repeat (2) @(negedge clk);
    send_value(4, 16'h0009, 16'h0009, 1'b0, 1'b0);
    send_value(4, 16'h00F1, 16'hFFF1, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk_eq("stall_chunk_ready", 32'(bus.chunk_ready), 32'd0);
      chk_eq("stall_valid", 32'(bus.valid_out), 32'd1);
      chk_eq("stall_product", 32'(bus.product), 32'h0009);
    end
    chk_eq("pre_overrun", 32'(bus.overrun), 32'd0);
    bus.p = 2'b11;
    bus.newOut = 1'b1;
    @(posedge clk);
    #1 bus.newOut = 1'b0;
    @(negedge clk);
    chk_eq("overrun_set", 32'(bus.overrun), 32'd1);
    rdy_force = 1'b1;
    wait_drain();
    chk_eq("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Asynchronous reset with a parked result and a half-collected product
    rdy_force = 1'b0;
    repeat (2) @(negedge clk);
    send_value(4, 16'h0009, 16'h0009, 1'b0, 1'b0);
    bus.bitSize = 4'd4;
    send_chunk(2'b01);
    send_chunk(2'b10);
    @(negedge clk);
    chk_eq("pre_rst_valid", 32'(bus.valid_out), 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_eq("arst_valid", 32'(bus.valid_out), 32'd0);
    chk_eq("arst_product", 32'(bus.product), 32'd0);
    chk_eq("arst_overrun", 32'(bus.overrun), 32'd0);
    chk_eq("arst_chunk_ready", 32'(bus.chunk_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    send_value(4, 16'h00F1, 16'hFFF1, 1'b0, 1'b0);
    wait_drain();

    // Randomized signed products with random gaps and output stalls
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bs_raw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(1, W));
      bse  = eff_w(bs_raw);
      a    = int'($urandom_range(0, (1 << bse) - 1)) - (1 << (bse - 1));
      b    = int'($urandom_range(0, (1 << bse) - 1)) - (1 << (bse - 1));
      prod = a * b;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_value(bs_raw, 16'(prod), 16'(prod), ($urandom_range(0, 3) == 0), 1'b1);
    end
    rnd_rdy = 1'b0;
    rdy_force = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain();
    chk_eq("rand_no_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
